// File: rtl/spe_pkg.sv
// Shared definitions for the spiking processing element: packet layout,
// router opcodes and the per-neuron state encoding.
package spe_pkg;

    // Packet layout: [32:29] destination, [28:25] opcode, [24:0] data
    localparam int PKT_W    = 33;
    localparam int ADDR_W   = 4;
    localparam int OP_W     = 4;
    localparam int DATA_W   = 25;
    localparam int ADDR_MSB = 32;
    localparam int ADDR_LSB = 29;
    localparam int OP_MSB   = 28;
    localparam int OP_LSB   = 25;
    localparam int DATA_MSB = 24;
    localparam int DATA_LSB = 0;

    // Opcodes shared by every SPE instance
    localparam logic [OP_W-1:0] OP_PSUM          = 4'd12;
    localparam logic [OP_W-1:0] OP_TIMESTEP_DONE = 4'd15;

    // Guard bits above the potential width so five psums plus a residual
    // can never wrap before saturation at FIRE
    localparam int ACC_GUARD = 4;

    // Opcode this SPE uses to deliver a {residual, spike} packet
    function automatic logic [OP_W-1:0] op_send(input int id);
        return OP_W'(2 * id);
    endfunction

    // Opcode this SPE uses to ask output memory for the previous residual
    function automatic logic [OP_W-1:0] op_req(input int id);
        return OP_W'(2 * id + 1);
    endfunction

    typedef enum logic [2:0] {
        ACCUM,
        REQ,
        WAIT_RES,
        FIRE,
        SEND
    } spe_state_e;

endpackage

// File: rtl/spe_threshold.sv
// Combinational neuron update: saturate the wide accumulator to the
// potential range, compare against the threshold and apply subtractive reset.
module spe_threshold
    import spe_pkg::*;
#(
    parameter int SUM_WIDTH = 13,
    parameter int ACC_WIDTH = 17,
    parameter int THRESHOLD = 64
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic signed [SUM_WIDTH-1:0] residual_o,
    output logic                        spike_o
);

    localparam logic signed [ACC_WIDTH-1:0] POS_MAX = ACC_WIDTH'((1 << (SUM_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] NEG_MIN = ACC_WIDTH'(-(1 << (SUM_WIDTH - 1)));
    localparam logic signed [SUM_WIDTH-1:0] TH      = SUM_WIDTH'(THRESHOLD);

    logic signed [SUM_WIDTH-1:0] pot_sat;

    // Clamp to the signed potential range, then fire and subtract if at/above threshold
    always_comb begin
        pot_sat    = acc_i[SUM_WIDTH-1:0];
        residual_o = '0;
        spike_o    = 1'b0;
        if (acc_i > POS_MAX) begin
            pot_sat = POS_MAX[SUM_WIDTH-1:0];
        end else if (acc_i < NEG_MIN) begin
            pot_sat = NEG_MIN[SUM_WIDTH-1:0];
        end
        if (pot_sat >= TH) begin
            spike_o    = 1'b1;
            residual_o = pot_sat - TH;
        end else begin
            spike_o    = 1'b0;
            residual_o = pot_sat;
        end
    end

endmodule

// File: rtl/spe_accum.sv
// Spiking processing element feeding output memory. Sums NUM_PSUMS partial
// sums per neuron, in timestep 2 folds in the stored residual fetched from
// output memory, then thresholds and emits a {residual, spike} packet.
module spe_accum
    import spe_pkg::*;
#(
    parameter int SPE_ID    = 0,
    parameter int OMEM_ADDR = 9,
    parameter int NUM_PSUMS = 5,
    parameter int SUM_WIDTH = 13,
    parameter int THRESHOLD = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_packet,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_packet,
    output logic [1:0]       ts,
    output logic             proto_err
);

    localparam int ACC_WIDTH = SUM_WIDTH + ACC_GUARD;
    localparam int CNT_W     = (NUM_PSUMS > 1) ? $clog2(NUM_PSUMS) : 1;
    localparam int EXT_W     = DATA_W - 1 - SUM_WIDTH;

    localparam logic [ADDR_W-1:0] DEST     = ADDR_W'(OMEM_ADDR);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_PSUMS - 1);
    localparam logic [PKT_W-1:0]  REQ_PKT  = {DEST, op_req(SPE_ID), DATA_W'(SPE_ID * 2)};

    spe_state_e                  state_q, state_d;
    logic [1:0]                  ts_q, ts_d;
    logic [CNT_W-1:0]            psum_cnt_q, psum_cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic [PKT_W-1:0]            out_packet_q, out_packet_d;
    logic                        proto_err_q, proto_err_d;

    logic                        in_fire;
    logic                        out_fire;
    logic [OP_W-1:0]             in_op;
    logic [DATA_W-1:0]           in_data;
    logic signed [ACC_WIDTH-1:0] psum_ext;
    logic signed [ACC_WIDTH-1:0] resid_ext;
    logic signed [SUM_WIDTH-1:0] thr_residual;
    logic                        thr_spike;
    logic                        unused_in_bits;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign in_op    = in_packet[OP_MSB:OP_LSB];
    assign in_data  = in_packet[DATA_MSB:DATA_LSB];

    // A psum sits in the low SUM_WIDTH data bits; a residual reply carries
    // the previous residual in data[SUM_WIDTH:1] with the old spike in bit 0
    assign psum_ext  = {{ACC_GUARD{in_data[SUM_WIDTH-1]}}, in_data[SUM_WIDTH-1:0]};
    assign resid_ext = {{ACC_GUARD{in_data[SUM_WIDTH]}}, in_data[SUM_WIDTH:1]};

    // Destination and upper data bits of incoming packets carry no meaning here
    assign unused_in_bits = &{1'b0, in_packet[ADDR_MSB:ADDR_LSB], in_data[DATA_MSB:SUM_WIDTH+1], in_data[0]};

    spe_threshold #(
        .SUM_WIDTH (SUM_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_threshold (
        .acc_i      (acc_q),
        .residual_o (thr_residual),
        .spike_o    (thr_spike)
    );

    // State and datapath registers; reset aborts the neuron and drops any pending packet
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            ts_q         <= 2'd1;
            psum_cnt_q   <= '0;
            acc_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            psum_cnt_q   <= psum_cnt_d;
            acc_q        <= acc_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Next-state and datapath updates for the per-neuron sequence
    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q;
        psum_cnt_d   = psum_cnt_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        proto_err_d  = proto_err_q;

        case (state_q)
            ACCUM: begin
                if (in_fire) begin
                    if (in_op == OP_PSUM) begin
                        acc_d = acc_q + psum_ext;
                        if (psum_cnt_q == CNT_LAST) begin
                            psum_cnt_d = '0;
                            if (ts_q == 2'd2) begin
                                // Request goes out on the same edge we leave ACCUM
                                state_d      = REQ;
                                out_packet_d = REQ_PKT;
                                out_valid_d  = 1'b1;
                            end else begin
                                state_d = FIRE;
                            end
                        end else begin
                            psum_cnt_d = psum_cnt_q + 1'b1;
                        end
                    end else if (in_op == OP_TIMESTEP_DONE) begin
                        // Timestep boundary is only legal between neurons; ts saturates at 2
                        if (psum_cnt_q == '0) begin
                            ts_d = 2'd2;
                        end else begin
                            proto_err_d = 1'b1;
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end

            REQ: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = WAIT_RES;
                end
            end

            WAIT_RES: begin
                // Whatever arrives next is the residual reply; its opcode is not checked
                if (in_fire) begin
                    acc_d   = acc_q + resid_ext;
                    state_d = FIRE;
                end
            end

            FIRE: begin
                // Packet is loaded here; it becomes valid on the following edge
                out_packet_d = {DEST, op_send(SPE_ID),
                                {{EXT_W{thr_residual[SUM_WIDTH-1]}}, thr_residual, thr_spike}};
                state_d      = SEND;
            end

            SEND: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    psum_cnt_d  = '0;
                    state_d     = ACCUM;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Accept router traffic only in states that consume packets
    always_comb begin
        in_ready_d = (state_d == ACCUM) || (state_d == WAIT_RES);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_packet = out_packet_q;
    assign ts         = ts_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_spe_accum.sv
// Directed testbench for spe_accum (SPE_ID=2, so send opcode 4, request opcode 5).
module tb_spe_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_packet;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_packet;
    logic [1:0]  ts;
    logic        proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    spe_accum #(
        .SPE_ID    (2),
        .OMEM_ADDR (9),
        .NUM_PSUMS (5),
        .SUM_WIDTH (13),
        .THRESHOLD (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_packet  (in_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .ts         (ts),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    function automatic logic [32:0] mk_pkt(input logic [3:0] dest, input logic [3:0] op,
                                           input logic [24:0] data);
        return {dest, op, data};
    endfunction

    // Present one packet and hold it until the DUT takes it
    task automatic send_pkt(input logic [3:0] op, input logic [24:0] data);
        int k;
        in_packet = mk_pkt(4'd2, op, data);
        in_valid  = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            check_val("send_timeout", in_ready, 1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_psum(input int v);
        logic [31:0] w;
        w = v;
        send_pkt(4'd12, {12'd0, w[12:0]});
    endtask

    task automatic send_neuron(input int a, input int b, input int c, input int d, input int e);
        send_psum(a); send_psum(b); send_psum(c); send_psum(d); send_psum(e);
    endtask

    // Accept one outgoing packet
    task automatic recv_pkt(output logic [32:0] pkt);
        int k;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        pkt = out_packet;
        if (!out_valid) begin
            check_val("recv_timeout", out_valid, 1);
        end else begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    logic [32:0] pkt;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_packet = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_packet", out_packet, 0);
        check_val("rst_ts", ts, 1);
        check_val("rst_proto_err", proto_err, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_in_ready", in_ready, 1);

        // ts1: 80 -> residual 16, spike; check output latency N+2
        send_neuron(10, 20, 5, 15, 30);
        check_val("lat1_edgeN", out_valid, 0);
        @(posedge clk); #1;
        check_val("lat1_edgeN1", out_valid, 0);
        check_val("lat1_in_ready_fire", in_ready, 0);
        @(posedge clk); #1;
        check_val("lat1_edgeN2", out_valid, 1);
        recv_pkt(pkt);
        check_val("n1_pkt", pkt, mk_pkt(4'd9, 4'd4, 25'd33));

        // ts1: 15 -> no spike, held in SEND for 10 cycles with a psum waiting
        send_neuron(1, 2, 3, 4, 5);
        begin
            int k = 0;
            while (!out_valid && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
        end
        in_packet = mk_pkt(4'd2, 4'd12, 25'd100);
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_val("hold_packet", out_packet, mk_pkt(4'd9, 4'd4, 25'd30));
            check_val("hold_valid", out_valid, 1);
            check_val("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        recv_pkt(pkt);
        check_val("n2_pkt", pkt, mk_pkt(4'd9, 4'd4, 25'd30));
        check_val("n2_single_xfer", out_valid, 0);
        @(posedge clk); #1;
        check_val("n2_single_xfer2", out_valid, 0);

        // Saturation: 20000 clamps to 4095 -> 4031, spike
        send_neuron(4000, 4000, 4000, 4000, 4000);
        recv_pkt(pkt);
        check_val("sat_pkt", pkt, mk_pkt(4'd9, 4'd4, 25'd8063));

        // Negative potential: -50, no spike -> -100 in 25 bits
        send_neuron(-10, -10, -10, -10, -10);
        recv_pkt(pkt);
        check_val("neg_pkt", pkt, mk_pkt(4'd9, 4'd4, 25'd33554332));

        // Exactly at threshold: residual 0, spike
        send_neuron(12, 13, 13, 13, 13);
        recv_pkt(pkt);
        check_val("th_eq_pkt", pkt, mk_pkt(4'd9, 4'd4, 25'd1));

        // Timestep-done mid-neuron is an error and is dropped
        send_psum(1);
        send_psum(2);
        send_pkt(4'd15, 25'd0);
        check_val("mid_tsd_err", proto_err, 1);
        check_val("mid_tsd_ts", ts, 1);
        send_psum(3); send_psum(4); send_psum(5);
        recv_pkt(pkt);
        check_val("mid_tsd_pkt", pkt, mk_pkt(4'd9, 4'd4, 25'd30));

        // Clear the sticky error
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("rst2_proto_err", proto_err, 0);

        // ts2: 50 + residual 16 = 66 -> residual 2, spike
        send_pkt(4'd15, 25'd0);
        check_val("ts2_ts", ts, 2);
        check_val("ts2_no_err", proto_err, 0);
        send_neuron(10, 10, 10, 10, 10);
        recv_pkt(pkt);
        check_val("ts2_req_pkt", pkt, mk_pkt(4'd9, 4'd5, 25'd4));
        send_pkt(4'd0, 25'd33);
        check_val("lat2_edgeM", out_valid, 0);
        @(posedge clk); #1;
        check_val("lat2_edgeM1", out_valid, 0);
        @(posedge clk); #1;
        check_val("lat2_edgeM2", out_valid, 1);
        recv_pkt(pkt);
        check_val("ts2_send_pkt", pkt, mk_pkt(4'd9, 4'd4, 25'd5));

        // Another timestep-done at ts2 is ignored
        send_pkt(4'd15, 25'd0);
        check_val("ts2_again_ts", ts, 2);
        check_val("ts2_again_err", proto_err, 0);

        // Reset while waiting for the residual reply
        send_neuron(1, 2, 3, 4, 5);
        recv_pkt(pkt);
        check_val("mid_req_pkt", pkt, mk_pkt(4'd9, 4'd5, 25'd4));
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_in_ready", in_ready, 0);
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_out_packet", out_packet, 0);
        check_val("midrst_ts", ts, 1);
        check_val("midrst_proto_err", proto_err, 0);
        reset = 1'b0;

        // Back at ts1: no request, straight to send
        send_neuron(1, 2, 3, 4, 5);
        recv_pkt(pkt);
        check_val("after_rst_pkt", pkt, mk_pkt(4'd9, 4'd4, 25'd30));

        // Unknown opcode flags an error
        send_pkt(4'd3, 25'd7);
        check_val("bad_op_err", proto_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
